// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM state, buffer entry layout and default
// parameters for instr_fetch_stage and its fetch_fifo.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int unsigned DEF_BUF_DEPTH = 2;
    localparam logic [63:0] DEF_RESET_PC  = 64'h0;

    // 96-bit buffer entry: instruction word plus its word address
    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer FIFO of fetch_entry_t with synchronous flush.
// Ports: clk, rst, flush, push/wdata, pop/rdata (zero when empty), empty, count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_BUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               wdata,
    input  logic                       pop,
    output fetch_entry_t               rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != FULL_CNT) || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC/FSM, single-cycle imem interface, fetch buffer.
// Ports: clk, rst, halt, redirect/redirect_pc, imem_req/addr/rdata,
// out_valid/ready/instr/pc; FETCH_PERF_EN adds perf_fetched/perf_redirects.
module instr_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = DEF_RESET_PC,
    parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_redirects
`endif
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t state;
    logic [63:0]  pc;
    logic [63:0]  inflight_pc;
    logic         inflight;
    logic [CW-1:0] count;
    logic [CW:0]  occupancy;
    logic         empty;
    logic         pop;
    logic         push;
    fetch_entry_t head;
    fetch_entry_t tail;

    assign out_valid = !empty;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign pop       = out_valid && out_ready;
    // A response is dropped (never written) if a redirect lands with it
    assign push      = inflight && !redirect;
    assign tail      = '{instr: imem_rdata, pc: inflight_pc};

    // Slots committed after this edge; a pop this cycle frees its slot
    // early so a full-rate stream does not bubble.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

    assign imem_req  = (state == RUN) && !redirect &&
                       (occupancy < (CW+1)'(BUF_DEPTH));
    assign imem_addr = pc;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .wdata (tail),
        .pop   (pop),
        .rdata (head),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) inflight_pc <= pc;
            if (redirect)      pc <= redirect_pc;
            else if (imem_req) pc <= pc + 64'd1;
            unique case (state)
                IDLE:    state <= RUN;
                RUN:     if (halt && !redirect) state <= HALTED;
                HALTED:  if (!halt || redirect) state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
        end else begin
            if (pop && (perf_fetched != 32'hFFFF_FFFF))
                perf_fetched <= perf_fetched + 32'd1;
            if (redirect && (perf_redirects != 32'hFFFF_FFFF))
                perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: directed scenarios then random
// ready/halt/redirect/reset traffic checked against a sequential-stream model.
module tb_instr_fetch_stage;

    localparam int          DEPTH = 2;
    localparam logic [63:0] RPC   = 64'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;
    int          m_fetched = 0;
    int          m_redirects = 0;
`endif

    int checks = 0;
    int fails = 0;
    int hs_count = 0;

    always #5 clk = ~clk;

    instr_fetch_stage #(
        .RESET_PC  (RPC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_redirects (perf_redirects)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0262_8467;
    endfunction

    // Instruction memory: data one cycle after the request
    always @(posedge clk)
        imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Expected delivery order: sequential word addresses from a start point
    logic [63:0] exp_q[$];

    task automatic fill(input logic [63:0] start);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(start + 64'(i));
    endtask

    logic        p_rst = 1'b0;
    logic        p_redir = 1'b0;
    logic [63:0] p_rpc = '0;
    logic        p_valid = 1'b0;
    logic        p_ready = 1'b0;
    logic [31:0] p_instr = '0;
    logic [63:0] p_pc = '0;
    logic        p_halt_run = 1'b0;
    int          low_cycles = 0;
    int          stall_reqs = 0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            if (p_rst) begin
                check("rst_valid", out_valid, 0);
                check("rst_req", imem_req, 0);
                check("rst_pc", out_pc, 0);
                check("rst_instr", out_instr, 0);
            end
            fill(RPC);
            low_cycles = 0;
            stall_reqs = 0;
            p_halt_run = 1'b0;
`ifdef FETCH_PERF_EN
            m_fetched = 0;
            m_redirects = 0;
`endif
        end else begin
`ifdef FETCH_PERF_EN
            check("perf_fetched", perf_fetched, 64'(m_fetched));
            check("perf_redirects", perf_redirects, 64'(m_redirects));
`endif
            if (p_rst) begin
                check("post_rst_valid", out_valid, 0);
                check("post_rst_req", imem_req, 0);
            end
            if (p_redir && !p_rst) begin
                check("flush_valid", out_valid, 0);
                if (!redirect) begin
                    check("redir_req", imem_req, 1);
                    check("redir_addr", imem_addr, p_rpc);
                end
            end
            if (p_valid && !p_ready && !p_redir && !p_rst) begin
                check("hold_valid", out_valid, 1);
                check("hold_instr", out_instr, 64'(p_instr));
                check("hold_pc", out_pc, p_pc);
            end
            if (p_halt_run) check("halted_noreq", imem_req, 0);
            if (out_ready || redirect) stall_reqs = 0;
            else if (imem_req) begin
                stall_reqs++;
                check("stall_bound", 64'(stall_reqs <= DEPTH), 1);
            end
            if (out_valid && out_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    check("sb_empty", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", out_pc, e);
                    check("sb_instr", out_instr, 64'(mem_word(e)));
                    if (exp_q.size() < 4) exp_q.push_back(exp_q[$] + 64'd1);
                end
            end
            if (redirect) fill(redirect_pc);
`ifdef FETCH_PERF_EN
            if (out_valid && out_ready) m_fetched++;
            if (redirect) m_redirects++;
`endif
            p_halt_run = halt && !redirect && (low_cycles >= 1);
            low_cycles++;
        end
        p_rst   = rst;
        p_redir = redirect;
        p_rpc   = redirect_pc;
        p_valid = out_valid;
        p_ready = out_ready;
        p_instr = out_instr;
        p_pc    = out_pc;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("c0_req", imem_req, 0);
        @(negedge clk);
        check("c1_req", imem_req, 1);
        check("c1_addr", imem_addr, 0);
        @(negedge clk);
        check("c2_valid", out_valid, 0);
        @(negedge clk);
        check("c3_valid", out_valid, 1);
        check("c3_pc", out_pc, 0);
        check("c3_instr", out_instr, 64'h0262_8467);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("seq_valid", out_valid, 1);
            check("seq_pc", out_pc, 64'(i));
        end

        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("bp_req", imem_req, 0);
        check("bp_valid", out_valid, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;

        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 64'd50;
        @(posedge clk);
        #1 redirect = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rd_valid", out_valid, 0);
        check("rd_req", imem_req, 1);
        check("rd_addr", imem_addr, 64'd50);

        repeat (3) @(posedge clk);
        #1 halt = 1'b1;
        repeat (4) @(negedge clk);
        check("halt_valid", out_valid, 0);
        check("halt_req", imem_req, 0);
        @(posedge clk);
        #1 halt = 1'b0;
        @(negedge clk);
        check("unhalt_req0", imem_req, 0);
        @(negedge clk);
        check("unhalt_req1", imem_req, 1);

        repeat (3) @(posedge clk);
        #1 redirect = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        check("wrap_a0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        check("wrap_a1", imem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        check("wrap_req", imem_req, 1);
        check("wrap_a2", imem_addr, 64'h0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mr_valid", out_valid, 0);
        check("mr_req", imem_req, 0);
        @(negedge clk);
        check("mr_req1", imem_req, 1);
        check("mr_addr", imem_addr, RPC);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) halt = ~halt;
            redirect = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF -
                              64'($urandom_range(0, 3));
            else
                redirect_pc = {$urandom, $urandom};
            rst = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        redirect = 1'b0;
        halt = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("handshakes", 64'(hs_count > 200), 1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, word address loaded into the PC on reset.
REQ-002 Parameter BUF_DEPTH, default 2, number of entries in the fetch buffer (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 halt  input  1  stops new fetches; buffered entries still drain.
REQ-006 redirect  input  1  next-PC override from the branch stage (taken beq).
REQ-007 redirect_pc  input  64  word address to fetch after a redirect.
REQ-008 imem_req  output  1  instruction-memory read strobe.
REQ-009 imem_addr  output  64  word address presented with imem_req.
REQ-010 imem_rdata  input  32  instruction returned exactly one cycle after imem_req.
REQ-011 out_valid  output  1  out_instr/out_pc hold a valid instruction.
REQ-012 out_ready  input  1  downstream (branch datapath) accepts the head entry.
REQ-013 out_instr  output  32  fetched instruction.
REQ-014 out_pc  output  64  word address of out_instr.

Function
REQ-015 FSM states SHALL be IDLE, RUN, HALTED: IDLE->RUN one cycle after rst deasserts; RUN->HALTED when halt=1; HALTED->RUN when halt=0 or redirect=1.
REQ-016 In RUN, imem_req SHALL be 1 iff redirect=0 and (buffered count + in-flight) < BUF_DEPTH; imem_addr=pc then; imem_req SHALL be 0 in IDLE and HALTED.
REQ-017 On each issued request, pc SHALL advance by 1 (word addressing), wrapping 64'hFFFF_FFFF_FFFF_FFFF to 0.
REQ-018 imem_rdata SHALL be written with its issuing PC into the buffer tail at the end of the cycle after the request; first out_valid SHALL appear 3 cycles after the request-issue cycle's predecessor (issue N, capture end N+1, out_valid N+2).
REQ-019 out_valid SHALL equal buffer-not-empty; head SHALL pop when out_valid&&out_ready; out_instr/out_pc SHALL stay stable while out_valid&&!out_ready.
REQ-020 Simultaneous push and pop SHALL leave the count unchanged; the buffer SHALL never overflow or underflow.
REQ-021 redirect=1 SHALL, at that edge, flush all buffer entries, mark any in-flight response as discarded, load pc<=redirect_pc, and issue no request that cycle; redirect SHALL take priority over halt, push and pop.
REQ-022 A pop and redirect in the same cycle SHALL complete the pop handshake (entry consumed) and then flush.
REQ-023 Redirect in HALTED SHALL load pc and return to RUN; fetch resumes next cycle.

Reset
REQ-024 rst=1 SHALL set pc=RESET_PC, state=IDLE, buffer empty, in-flight cleared; imem_req=0, out_valid=0, out_instr=0, out_pc=0 during and after reset.
REQ-025 rst asserted mid-operation SHALL discard all buffered and in-flight instructions; rst overrides redirect.

Configuration
REQ-026 Macro FETCH_PERF_EN SHALL add outputs perf_fetched[31:0] (count of out handshakes) and perf_redirects[31:0] (count of redirect cycles), both saturating at 32'hFFFF_FFFF and cleared by rst.
REQ-027 Without FETCH_PERF_EN those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-028 Shared package fetch_pkg SHALL hold the FSM state type, default BUF_DEPTH and default RESET_PC constants.
REQ-029 The buffer SHALL be a sub-module fetch_fifo (96-bit entries: instr+pc, with flush input).

Verification
REQ-030 Reset release, out_ready=1, imem returns 32'h0262_8467 at addr 0 -> imem_req at cycle 1 addr 0, out_valid cycle 3 with out_pc=0, out_instr=32'h0262_8467, then one instruction per cycle with out_pc 1,2,3.
REQ-031 out_ready=0 for 5 cycles -> exactly BUF_DEPTH entries buffered, imem_req=0 once full, outputs stable; release -> in-order delivery, none lost or duplicated.
REQ-032 redirect=1, redirect_pc=50 while buffer full and a request in flight -> next cycle out_valid=0, imem_addr=50; first out_pc after redirect =50.
REQ-033 halt=1 for 4 cycles -> no imem_req, buffer drains, state HALTED; halt=0 -> fetch resumes at next sequential pc.
REQ-034 pc=64'hFFFF_FFFF_FFFF_FFFF issued -> next imem_addr=0; rst mid-stream -> out_valid=0 next cycle, fetch restarts at RESET_PC.
REQ-035 With FETCH_PERF_EN: 10 handshakes and 2 redirects -> perf_fetched=10, perf_redirects=2.
